// File: rtl/clkdiv_sched.sv
// Shared clock divider with round-robin ownership: one requester at a time gets a
// divided clock at its own ratio. Optional tick budget per grant: CLKDIV_TIMEOUT_EN.
module clkdiv_sched #(
    parameter int NREQ      = 4,
    parameter int CW        = 7,
    parameter int MAX_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   div_in,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic                 tick,
    output logic                 clkout
);

    // state | meaning
    // IDLE  | no owner; arbitrate round-robin among active requests
    // LOAD  | owner chosen; latch its divide ratio, start count at 1
    // RUN   | dividing; leave when owner drops req (or budget spent)
    // DRAIN | keep dividing until a tick that leaves clkout low, then release

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   ptr;
    logic [OW-1:0]   pick;
    logic            pick_vld;
    logic [CW-1:0]   count;
    logic [CW-1:0]   nl;
    logic [CW-1:0]   div_sel;
    logic            owner_req;
    logic            budget_hit;
    logic            counting;

    function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return OW'(s);
    endfunction

    assign owner_req = req[owner];
    assign div_sel   = div_in[owner*CW +: CW];
    assign counting  = (state == RUN) || (state == DRAIN);
    assign tick      = counting && (count == nl);
    assign busy      = (state != IDLE);

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[rr_idx(ptr, k)]) begin
                pick     = rr_idx(ptr, k);
                pick_vld = 1'b1;
            end
        end
    end

`ifdef CLKDIV_TIMEOUT_EN
    localparam int TW = $clog2(MAX_TICKS + 1);
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state == LOAD) begin
            tcnt <= '0;
        end else if ((state == RUN) && tick) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Owner is already lowest priority afterwards since ptr sits just past it.
    assign budget_hit = (state == RUN) && tick && (tcnt == TW'(MAX_TICKS - 1));
`else
    assign budget_hit = 1'b0 && (MAX_TICKS > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_vld) state_nx = LOAD;
            end
            LOAD: begin
                state_nx = RUN;
            end
            RUN: begin
                if (!owner_req || budget_hit) state_nx = DRAIN;
            end
            DRAIN: begin
                if (tick) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant  <= '0;
            owner  <= '0;
            ptr    <= '0;
            count  <= '0;
            nl     <= CW'(1);
            clkout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner <= pick;
                        grant <= NREQ'(1) << pick;
                        ptr   <= (pick == OW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    end
                end
                LOAD: begin
                    nl    <= (div_sel == '0) ? CW'(1) : div_sel;
                    count <= CW'(1);
                end
                RUN: begin
                    if (tick) begin
                        count  <= CW'(1);
                        clkout <= ~clkout;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DRAIN: begin
                    // Any DRAIN tick ends the grant with clkout parked low,
                    // whether it falls from 1 or is already 0.
                    if (tick) begin
                        count  <= CW'(1);
                        clkout <= 1'b0;
                        grant  <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Directed bench for clkdiv_sched: a vector table for single-owner timing plus
// hand sequences for round-robin order, drain, reset abort and the tick budget.
module tb_clkdiv_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [27:0] div_in;
    logic [3:0]  grant;
    logic        busy;
    logic        tick;
    logic        clkout;

    int total = 0;
    int bad   = 0;

    clkdiv_sched #(.NREQ(4), .CW(7), .MAX_TICKS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .div_in (div_in),
        .grant  (grant),
        .busy   (busy),
        .tick   (tick),
        .clkout (clkout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [27:0] div;
        logic [3:0]  g;
        logic        b;
        logic        t;
        logic        c;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [27:0] d,
                       input logic [3:0] g, input logic b, input logic t, input logic c);
        vec_t v;
        v.rst = r; v.req = q; v.div = d; v.g = g; v.b = b; v.t = t; v.c = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s [%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int n;
    int nt;
    int guard;
    int k;

    initial begin
        rst = 1'b1; req = 4'h0; div_in = 28'h0;

        // reset; owner 0 at N=3 (div changed to 5 mid-RUN, non-owners toggling)
        add(1, 4'h0, 28'h3, 4'h0, 0, 0, 0);
        add(0, 4'h1, 28'h3, 4'h1, 1, 0, 0);
        add(0, 4'h1, 28'h3, 4'h1, 1, 0, 0);
        add(0, 4'h1, 28'h5, 4'h1, 1, 0, 0);
        add(0, 4'h1, 28'h5, 4'h1, 1, 1, 0);
        add(0, 4'hB, 28'h5, 4'h1, 1, 0, 1);
        add(0, 4'hB, 28'h5, 4'h1, 1, 0, 1);
        add(0, 4'hB, 28'h5, 4'h1, 1, 1, 1);
        add(0, 4'hB, 28'h5, 4'h1, 1, 0, 0);
        add(0, 4'hB, 28'h5, 4'h1, 1, 0, 0);
        add(0, 4'h1, 28'h5, 4'h1, 1, 1, 0);
        // drop on a tick; owner re-raise and non-owners in DRAIN are ignored
        add(0, 4'h0, 28'h5, 4'h1, 1, 0, 1);
        add(0, 4'h1, 28'h5, 4'h1, 1, 0, 1);
        add(0, 4'hE, 28'h5, 4'h1, 1, 1, 1);
        add(0, 4'h0, 28'h5, 4'h0, 0, 0, 0);
        add(0, 4'h0, 28'h0, 4'h0, 0, 0, 0);
        // owner 0 with N=0 -> behaves as N=1
        add(0, 4'h1, 28'h0, 4'h1, 1, 0, 0);
        add(0, 4'h1, 28'h0, 4'h1, 1, 1, 0);
        add(0, 4'h1, 28'h0, 4'h1, 1, 1, 1);
        add(0, 4'h1, 28'h0, 4'h1, 1, 1, 0);
        add(0, 4'h0, 28'h0, 4'h1, 1, 1, 1);
        add(0, 4'h0, 28'h0, 4'h0, 0, 0, 0);
        // owner 2 with N=1; drain entered with clkout already low exits on next tick
        add(0, 4'h4, 28'h0004000, 4'h4, 1, 0, 0);
        add(0, 4'h4, 28'h0004000, 4'h4, 1, 1, 0);
        add(0, 4'h4, 28'h0004000, 4'h4, 1, 1, 1);
        add(0, 4'h0, 28'h0004000, 4'h4, 1, 1, 0);
        add(0, 4'h0, 28'h0004000, 4'h0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; req = tbl[i].req; div_in = tbl[i].div;
            @(posedge clk);
            @(negedge clk);
            chk("tbl_grant",  i, 32'(grant),  32'(tbl[i].g));
            chk("tbl_busy",   i, 32'(busy),   32'(tbl[i].b));
            chk("tbl_tick",   i, 32'(tick),   32'(tbl[i].t));
            chk("tbl_clkout", i, 32'(clkout), 32'(tbl[i].c));
        end

        // owner 0, N=4, drops req one cycle after first tick
        req = 4'h1; div_in = 28'h4;
        step();
        chk("drain_grant", 0, 32'(grant), 32'h1);
        for (int i = 0; i < 4; i++) step();
        chk("drain_tick1", 0, 32'(tick), 32'h1);
        chk("drain_clk1",  0, 32'(clkout), 32'h0);
        step();
        chk("drain_clkhi", 0, 32'(clkout), 32'h1);
        req = 4'h0;
        step();
        chk("drain_busy",  0, 32'(busy), 32'h1);
        chk("drain_hold",  0, 32'(grant), 32'h1);
        step();
        step();
        chk("drain_tick2", 0, 32'(tick), 32'h1);
        chk("drain_clk2",  0, 32'(clkout), 32'h1);
        step();
        chk("drain_rel",   0, 32'(grant), 32'h0);
        chk("drain_clk0",  0, 32'(clkout), 32'h0);
        chk("drain_idle",  0, 32'(busy), 32'h0);

        // round-robin with all requesting, each owner drops after 2 ticks
        rst = 1'b1; req = 4'h0;
        step();
        rst = 1'b0; req = 4'hF; div_in = {4{7'd1}};
        step();
        for (int i = 0; i < 5; i++) begin
            k = i % 4;
            chk("rr_grant", i, 32'(grant), 32'(4'h1 << k));
            nt = 0; guard = 0;
            while (nt < 2 && guard < 40) begin
                if (tick) nt++;
                if (nt < 2) step();
                guard++;
            end
            chk("rr_ticks", i, 32'(nt), 32'd2);
            req[k] = 1'b0;
            guard = 0;
            while (grant != 4'h0 && guard < 40) begin
                step();
                guard++;
            end
            chk("rr_released", i, 32'(grant), 32'h0);
            chk("rr_gap_low",  i, 32'(busy), 32'h0);
            req[k] = 1'b1;
            step();
            chk("rr_gap_one",  i, 32'(busy), 32'h1);
        end
        req = 4'h0;

        // reset mid-RUN: owner 1, N=5, count=3
        rst = 1'b1;
        step();
        rst = 1'b0; req = 4'h1; div_in = 28'h0;
        step();
        req = 4'h0;
        guard = 0;
        while (busy && guard < 20) begin
            step();
            guard++;
        end
        chk("rst_pre_idle", 0, 32'(busy), 32'h0);
        req = 4'h2; div_in = {7'd0, 7'd0, 7'd5, 7'd0};
        step();
        chk("rst_pre_grant", 0, 32'(grant), 32'h2);
        for (int i = 0; i < 3; i++) step();
        chk("rst_pre_busy", 0, 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        chk("rst_grant",  0, 32'(grant), 32'h0);
        chk("rst_clkout", 0, 32'(clkout), 32'h0);
        chk("rst_tick",   0, 32'(tick), 32'h0);
        chk("rst_busy",   0, 32'(busy), 32'h0);
        rst = 1'b0; req = 4'hF; div_in = {4{7'd2}};
        step();
        chk("rst_rr_from0", 0, 32'(grant), 32'h1);
        step();
        chk("rst_no_tick", 0, 32'(tick), 32'h0);

        rst = 1'b1; req = 4'h0;
        step();
        rst = 1'b0; req = 4'h3; div_in = {7'd0, 7'd0, 7'd2, 7'd2};
        step();
        chk("budget_grant0", 0, 32'(grant), 32'h1);
`ifdef CLKDIV_TIMEOUT_EN
        n = 0; nt = 0;
        while (grant != 4'h0 && n < 40) begin
            step();
            n++;
            if (tick) nt++;
        end
        chk("budget_cycles", 0, 32'(n), 32'd11);
        chk("budget_ticks",  0, 32'(nt), 32'd5);
        step();
        chk("budget_next",   0, 32'(grant), 32'h2);
`else
        nt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) nt++;
        end
        chk("nobudget_ticks", 0, 32'(nt), 32'd10);
        chk("nobudget_grant", 0, 32'(grant), 32'h1);
        chk("nobudget_busy",  0, 32'(busy), 32'h1);
`endif
        req = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
